// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared op encodings, FSM state type and memory map constants
package mips_pkg;

    localparam logic [31:0] MEM_START = 32'h0000_0000;
    localparam int          MEM_DEPTH = 1024;

    typedef enum logic [2:0] {
        MDU_MULT  = 3'b000,
        MDU_MULTU = 3'b001,
        MDU_DIV   = 3'b010,
        MDU_DIVU  = 3'b011,
        MDU_MTHI  = 3'b100,
        MDU_MTLO  = 3'b101
    } mdu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_FIX  = 2'd3
    } mdu_state_e;

endpackage

// File: rtl/mult_div_unit_if.sv
// rtl/mult_div_unit_if.sv - request/result bundle between control path and mult_div_unit
interface mult_div_unit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] operand_a;
    logic [WIDTH-1:0] operand_b;
    logic             busy;
    logic             done;
    logic             div_by_zero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, operand_a, operand_b,
        input  busy, done, div_by_zero, hi, lo
    );

    modport slave (
        input  start, op, operand_a, operand_b,
        output busy, done, div_by_zero, hi, lo
    );
endinterface

// File: rtl/mult_div_unit.sv
// rtl/mult_div_unit.sv - iterative 32-step multiply/divide unit owning HI/LO
module mult_div_unit
    import mips_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic          clock,
    input  logic          reset_n,
    mult_div_unit_if.slave mdu
);

    localparam int CNT_W = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

    mdu_state_e         state_q, state_d;
    logic [CNT_W-1:0]   step_cnt;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   mag_a, mag_b;
    logic               neg_a, neg_res, is_div, b_zero;
    logic [WIDTH-1:0]   hi_r, lo_r;
    logic               busy_r, done_r, dbz_r;

    // Operand conditioning at acceptance: signed ops keep magnitudes plus sign flags
    logic               signed_op, neg_a_in, neg_b_in;
    logic [WIDTH-1:0]   mag_a_in, mag_b_in;
    logic               is_mul_req, is_div_req;

    always_comb begin
        signed_op  = (mdu.op == MDU_MULT) || (mdu.op == MDU_DIV);
        neg_a_in   = signed_op & mdu.operand_a[WIDTH-1];
        neg_b_in   = signed_op & mdu.operand_b[WIDTH-1];
        mag_a_in   = neg_a_in ? -mdu.operand_a : mdu.operand_a;
        mag_b_in   = neg_b_in ? -mdu.operand_b : mdu.operand_b;
        is_mul_req = mdu.start && ((mdu.op == MDU_MULT) || (mdu.op == MDU_MULTU));
        is_div_req = mdu.start && ((mdu.op == MDU_DIV)  || (mdu.op == MDU_DIVU));
    end

    logic [2*WIDTH-1:0] mul_addend;
    logic [WIDTH:0]     div_trial, div_diff;
    logic               div_ge;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quot_fix, rem_fix, raw_a;

    always_comb begin
        mul_addend = mag_b[step_cnt[CNT_W-2:0]]
                   ? ({{WIDTH{1'b0}}, mag_a} << step_cnt[CNT_W-2:0])
                   : '0;
        // acc holds {remainder, dividend-being-shifted-out / quotient-shifted-in}
        div_trial  = acc[2*WIDTH-1:WIDTH-1];
        div_diff   = div_trial - {1'b0, mag_b};
        div_ge     = (div_trial >= {1'b0, mag_b});
        prod_fix   = neg_res ? -acc : acc;
        quot_fix   = neg_res ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        rem_fix    = neg_a ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
        raw_a      = neg_a ? -mag_a : mag_a;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (is_mul_req)      state_d = ST_MUL;
                else if (is_div_req) state_d = ST_DIV;
            end
            ST_MUL:  if (step_cnt == LAST_STEP) state_d = ST_FIX;
            ST_DIV:  if (step_cnt == LAST_STEP) state_d = ST_FIX;
            ST_FIX:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            step_cnt <= '0;
            acc      <= '0;
            mag_a    <= '0;
            mag_b    <= '0;
            neg_a    <= 1'b0;
            neg_res  <= 1'b0;
            is_div   <= 1'b0;
            b_zero   <= 1'b0;
            hi_r     <= '0;
            lo_r     <= '0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            dbz_r    <= 1'b0;
        end else begin
            done_r <= 1'b0;
            dbz_r  <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (is_mul_req || is_div_req) begin
                        mag_a    <= mag_a_in;
                        mag_b    <= mag_b_in;
                        neg_a    <= neg_a_in;
                        neg_res  <= neg_a_in ^ neg_b_in;
                        is_div   <= is_div_req;
                        b_zero   <= (mdu.operand_b == '0);
                        step_cnt <= '0;
                        busy_r   <= 1'b1;
                        acc      <= is_div_req ? {{WIDTH{1'b0}}, mag_a_in} : '0;
                    end else if (mdu.start && mdu.op == MDU_MTHI) begin
                        hi_r <= mdu.operand_a;
                    end else if (mdu.start && mdu.op == MDU_MTLO) begin
                        lo_r <= mdu.operand_a;
                    end
                end
                ST_MUL: begin
                    acc      <= acc + mul_addend;
                    step_cnt <= step_cnt + 1'b1;
                end
                ST_DIV: begin
                    acc      <= div_ge ? {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1}
                                       : {acc[2*WIDTH-2:0], 1'b0};
                    step_cnt <= step_cnt + 1'b1;
                end
                ST_FIX: begin
                    if (!is_div) begin
                        hi_r <= prod_fix[2*WIDTH-1:WIDTH];
                        lo_r <= prod_fix[WIDTH-1:0];
                    end else if (b_zero) begin
                        hi_r <= raw_a;
                        lo_r <= '1;
                    end else begin
                        hi_r <= rem_fix;
                        lo_r <= quot_fix;
                    end
                    dbz_r    <= is_div & b_zero;
                    done_r   <= 1'b1;
                    busy_r   <= 1'b0;
                    step_cnt <= '0;
                end
                default: ;
            endcase
        end
    end

    assign mdu.busy        = busy_r;
    assign mdu.done        = done_r;
    assign mdu.div_by_zero = dbz_r;
    assign mdu.hi          = hi_r;
    assign mdu.lo          = lo_r;

endmodule

// File: doc/mult_div_unit.md
# mult_div_unit

- Iterative multiply/divide unit that owns the architectural HI and LO registers.
- Sits directly downstream of the register file's two read ports.
  - Consumes rs and rt values for MULT, MULTU, DIV, DIVU, MTHI and MTLO.
  - Exposes HI/LO for MFHI/MFLO writeback.
- Raises `busy` so the control unit stalls the PC while a 32-step operation runs.

## Interface
- `WIDTH`, 32: operand width. Products and the HI:LO pair are 2*WIDTH bits.
- `clock` in 1: single clock, rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `start` in 1: request strobe, sampled on the rising edge.
- `op` in 3: operation code.
  - 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO.
  - 110 and 111 are ignored.
- `operand_a` in WIDTH: rs value (register file s1 output).
- `operand_b` in WIDTH: rt value (register file s2 output).
- `busy` out 1: high while a multiply or divide is in progress.
- `done` out 1: one-cycle pulse when HI/LO take a multiply or divide result.
- `div_by_zero` out 1: high together with `done` when a DIV/DIVU had `operand_b` == 0.
- `hi` out WIDTH: HI register.
- `lo` out WIDTH: LO register.

## Operation
**States**
- IDLE, MUL, DIV, FIX.

**IDLE**
- `start` with MULT/MULTU: latch operand magnitudes (signed ops only) and sign flags, clear the 64-bit accumulator, clear the step counter, go to MUL.
- `start` with DIV/DIVU: latch operands the same way, clear the remainder, go to DIV.
- `start` with MTHI: `hi` <= `operand_a`; stay in IDLE; no `done`.
- `start` with MTLO: `lo` <= `operand_a`; stay in IDLE; no `done`.
- `start` with op 110/111: no effect.

**MUL**
- One shift-add step per cycle, LSB-first on the multiplier, 32 steps.
- After step 31, go to FIX.

**DIV**
- One restoring step per cycle, MSB-first on the dividend, 32 steps.
- After step 31, go to FIX.
- Divisor 0: still runs all 32 steps, so latency stays fixed.

**FIX**
- Write results, pulse `done`, return to IDLE.
- MULT: negate the 64-bit product if the operand signs differ. `hi` <= product[63:32], `lo` <= product[31:0].
- DIV quotient: negated if the signs differ.
- DIV remainder: takes the dividend's sign.
- -2^31 / -1 yields `lo` = 0x8000_0000, `hi` = 0.
- Divide by zero: `hi` <= `operand_a` (as latched), `lo` <= 0xFFFF_FFFF, `div_by_zero` = 1.

**Other rules**
- `start` while `busy` is ignored. Operands are not re-latched; HI/LO are untouched until FIX.
- Operands are latched at acceptance, so later changes on `operand_a`/`operand_b` have no effect.
- All arithmetic is on unsigned magnitudes. Sign handling happens only at latch and in FIX.

## Timing
**Reset values** (asynchronous, any state)
- `hi`, `lo`: 0.
- `busy`, `done`, `div_by_zero`: 0.
- State: IDLE. Step counter: 0.
- Asserting reset mid-operation abandons the operation with no `done`.

**Multiply/divide latency**
- Accepted at edge E0: `busy` is 1 from after E0 up to E33.
- Steps run at edges E1 to E32. FIX writes `hi`/`lo` at E33.
- `busy` falls after E33, and `done` (plus `div_by_zero`) is high for the one cycle after E33.
- Total: 33 cycles from acceptance to valid HI/LO.
- `busy` is registered (not combinational from `start`). The control unit asserts `start` for one cycle and stalls on `busy` from the next cycle.
- A new `start` is accepted in the same cycle `done` is high.

**MTHI/MTLO latency**
- Register updates at the accepting edge.
- `hi`/`lo` outputs are valid the following cycle. `busy` stays 0.

## Structure
**Shared package `mips_pkg`**
- Op encodings: `MDU_MULT`, `MDU_MULTU`, `MDU_DIV`, `MDU_DIVU`, `MDU_MTHI`, `MDU_MTLO`.
- FSM state type.
- `MEM_START` and `MEM_DEPTH` constants move here as well.

**Sub-modules**
- None needed. The FSM, 6-bit step counter, 64-bit accumulator/remainder datapath and sign fix-up live in one module.

## Test plan
- MULTU with 0xFFFF_FFFF × 0xFFFF_FFFF:
  - `busy` high for 33 cycles.
  - `done` pulses once.
  - `hi` = 0xFFFF_FFFE, `lo` = 0x0000_0001.
- MULT with -3 × 7:
  - `hi` = 0xFFFF_FFFF, `lo` = 0xFFFF_FFEB, after 33 cycles.
- DIV with -7 / 2:
  - `lo` = 0xFFFF_FFFD, `hi` = 0xFFFF_FFFF.
- DIV with 0x8000_0000 / 0xFFFF_FFFF:
  - `lo` = 0x8000_0000, `hi` = 0.
- DIVU with 100 / 0:
  - `done` and `div_by_zero` high together.
  - `hi` = 0x0000_0064, `lo` = 0xFFFF_FFFF.
- MTHI 0x1234, then MTLO 0x5678, on consecutive cycles:
  - `hi` = 0x1234 and `lo` = 0x5678.
  - `busy` and `done` never assert.
- Start MULTU 5×6, pulse `reset_n` low at step 10:
  - `hi`/`lo`/`busy` return to 0 immediately, with no `done`.
  - A new MULTU 5×6 then gives `lo` = 30.
- Start DIVU 9/3, then pulse `start` MTLO 0xAA while busy:
  - The MTLO is ignored.
  - Result `lo` = 3, `hi` = 0.
